// File: rtl/mem_arbiter_if.sv
// Request/grant bus between the three memory clients, the arbiter and the memory port.
// The slave modport is the arbiter's view; the master modport is the clients' and memory's view.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

interface mem_arbiter_if #(
    parameter int D = 32
);
    logic                      flush;
    logic                      dec_req;
    logic [`MEM_ADDR_SIZE-1:0] dec_addr;
    logic                      wb_req;
    logic [`MEM_ADDR_SIZE-1:0] wb_addr;
    logic                      cmp_req;
    logic [`MEM_ADDR_SIZE-1:0] cmp_addr;
    logic [D-1:0]              cmp_wdata;
    logic                      dec_ack;
    logic                      wb_ack;
    logic                      cmp_ack;
    logic                      dec_data_valid;
    logic                      wb_data_valid;
    logic [D-1:0]              rd_data;
    logic [`MEM_ADDR_SIZE-1:0] mem_addr;
    logic                      mem_ren;
    logic                      mem_wen;
    logic [D-1:0]              mem_wdata;
    logic [D-1:0]              mem_rdata;
    logic                      mem_rvalid;
    logic                      rsp_err;

    modport slave (
        input  flush, dec_req, dec_addr, wb_req, wb_addr, cmp_req, cmp_addr, cmp_wdata,
               mem_rdata, mem_rvalid,
        output dec_ack, wb_ack, cmp_ack, dec_data_valid, wb_data_valid, rd_data,
               mem_addr, mem_ren, mem_wen, mem_wdata, rsp_err
    );

    modport master (
        output flush, dec_req, dec_addr, wb_req, wb_addr, cmp_req, cmp_addr, cmp_wdata,
               mem_rdata, mem_rvalid,
        input  dec_ack, wb_ack, cmp_ack, dec_data_valid, wb_data_valid, rd_data,
               mem_addr, mem_ren, mem_wen, mem_wdata, rsp_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-client memory arbiter (dec/wb reads, cmp writes) with an in-order read tag FIFO.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority cmp > wb > dec instead of round-robin.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

module mem_arbiter #(
    parameter int MEM_BANDWIDTH = 4,
    parameter int TAG_DEPTH     = 4
) (
    input logic         clk,
    input logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int D  = MEM_BANDWIDTH * 8;
    localparam int AW = `MEM_ADDR_SIZE;
    localparam int PW = $clog2(TAG_DEPTH);

    logic [2:0]           req_v;
    logic [2:0]           gnt;
    logic                 rd_ok;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [PW:0]          count;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [TAG_DEPTH-1:0] tags;
    logic [AW-1:0]        addr_nxt;

    logic [AW-1:0]        addr_q;
    logic                 ren_q;
    logic                 wen_q;
    logic [D-1:0]         wdata_q;
    logic [D-1:0]         rd_data_q;
    logic                 dec_v_q;
    logic                 wb_v_q;
    logic                 err_q;

    assign rd_ok = (count != (PW+1)'(TAG_DEPTH));
    assign empty = (count == '0);
    assign req_v = {bus.cmp_req, bus.wb_req & rd_ok, bus.dec_req & rd_ok} & {3{~bus.flush}};

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        gnt = '0;
        if (req_v[2])      gnt = 3'b100;
        else if (req_v[1]) gnt = 3'b010;
        else if (req_v[0]) gnt = 3'b001;
    end
`else
    logic [1:0] rr_ptr;

    // rr_ptr names the client that is checked first this cycle
    always_comb begin
        gnt = '0;
        case (rr_ptr)
            2'd0: begin
                if (req_v[0])      gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
            end
            2'd1: begin
                if (req_v[1])      gnt = 3'b010;
                else if (req_v[2]) gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
            end
            default: begin
                if (req_v[2])      gnt = 3'b100;
                else if (req_v[0]) gnt = 3'b001;
                else if (req_v[1]) gnt = 3'b010;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 2'd0;
        end else if (bus.flush) begin
            rr_ptr <= 2'd0;
        end else if (gnt != '0) begin
            rr_ptr <= gnt[0] ? 2'd1 : (gnt[1] ? 2'd2 : 2'd0);
        end
    end
`endif

    assign bus.dec_ack = gnt[0];
    assign bus.wb_ack  = gnt[1];
    assign bus.cmp_ack = gnt[2];

    assign push = gnt[0] | gnt[1];
    // a response with nothing outstanding (or during flush) never touches the FIFO
    assign pop  = bus.mem_rvalid & ~empty & ~bus.flush;

    always_comb begin
        addr_nxt = bus.dec_addr;
        if (gnt[1])      addr_nxt = bus.wb_addr;
        else if (gnt[2]) addr_nxt = bus.cmp_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ren_q <= push;
            wen_q <= gnt[2];
            if (gnt != '0) addr_q  <= addr_nxt;
            if (gnt[2])    wdata_q <= bus.cmp_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tags   <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= gnt[1];
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_v_q   <= 1'b0;
            wb_v_q    <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            dec_v_q <= pop & ~tags[rd_ptr];
            wb_v_q  <= pop & tags[rd_ptr];
            if (pop) rd_data_q <= bus.mem_rdata;
            if (bus.flush)
                err_q <= 1'b0;
            else if (bus.mem_rvalid && empty)
                err_q <= 1'b1;
        end
    end

    assign bus.mem_addr       = addr_q;
    assign bus.mem_ren        = ren_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.dec_data_valid = dec_v_q;
    assign bus.wb_data_valid  = wb_v_q;
    assign bus.rsp_err        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

module tb_mem_arbiter;
    localparam int TD = 4;
    localparam int D  = 32;
    localparam int AW = `MEM_ADDR_SIZE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.D(D)) bus();

    mem_arbiter #(.MEM_BANDWIDTH(4), .TAG_DEPTH(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [D-1:0]  data;
    } cmd_t;
    typedef struct {
        bit           tag;
        logic [D-1:0] data;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    bit   out_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rr      = 0;
    bit exp_err = 1'b0;
    int wb_ack_cnt = 0;

    bit            dec_p, wb_p, cmp_p, rv, fl;
    logic [AW-1:0] dec_a, wb_a, cmp_a;
    logic [D-1:0]  cmp_d, rdat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.flush      = fl;
        bus.dec_req    = dec_p;
        bus.dec_addr   = dec_a;
        bus.wb_req     = wb_p;
        bus.wb_addr    = wb_a;
        bus.cmp_req    = cmp_p;
        bus.cmp_addr   = cmp_a;
        bus.cmp_wdata  = cmp_d;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rdat;
    endtask

    // reference arbitration: who should win given the pending requests and outstanding reads
    function automatic int pick();
        bit       rd_ok;
        bit [2:0] v;
        rd_ok = out_q.size() < TD;
        v = {cmp_p, wb_p && rd_ok, dec_p && rd_ok};
        if (fl) return -1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        for (int i = 2; i >= 0; i--) if (v[i]) return i;
`else
        for (int k = 0; k < 3; k++) if (v[(rr + k) % 3]) return (rr + k) % 3;
`endif
        return -1;
    endfunction

    task automatic cycle();
        int       g;
        bit [2:0] exp_ack;
        cmd_t     c;
        rsp_t     r;
        @(posedge clk);
        #1;
        drive();
        #2;
        g = pick();
        exp_ack = (g < 0) ? 3'b000 : (3'b001 << g);
        check("ack", {bus.cmp_ack, bus.wb_ack, bus.dec_ack}, exp_ack);
        check("rsp_err", bus.rsp_err, exp_err);
        if (bus.wb_ack) wb_ack_cnt++;
        if (fl) begin
            out_q.delete();
            rr = 0;
            exp_err = 1'b0;
        end else begin
            if (rv) begin
                if (out_q.size() > 0) begin
                    r.tag  = out_q.pop_front();
                    r.data = rdat;
                    rsp_q.push_back(r);
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (g >= 0) begin
                rr = (g + 1) % 3;
                c.wr   = (g == 2);
                c.addr = (g == 0) ? dec_a : ((g == 1) ? wb_a : cmp_a);
                c.data = (g == 2) ? cmp_d : '0;
                cmd_q.push_back(c);
                if (g < 2) out_q.push_back(g == 1);
                if (g == 0) dec_p = 1'b0;
                if (g == 1) wb_p = 1'b0;
                if (g == 2) cmp_p = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        if (rst_n) begin
            if (bus.mem_ren && bus.mem_wen) begin
                check("strobe_exclusive", 2'b11, 2'b01);
            end else if (bus.mem_ren || bus.mem_wen) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_wen", bus.mem_wen, c.wr);
                    check("cmd_addr", bus.mem_addr, c.addr);
                    if (c.wr) check("cmd_wdata", bus.mem_wdata, c.data);
                end
            end
            if (bus.dec_data_valid && bus.wb_data_valid) begin
                check("valid_exclusive", 2'b11, 2'b01);
            end else if (bus.dec_data_valid || bus.wb_data_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_route_wb", bus.wb_data_valid, r.tag);
                    check("rsp_data", bus.rd_data, r.data);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes_valids"},
              {bus.mem_ren, bus.mem_wen, bus.dec_data_valid, bus.wb_data_valid, bus.rsp_err}, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_rd_data"}, bus.rd_data, 0);
    endtask

    task automatic idle_inputs();
        dec_p = 0; wb_p = 0; cmp_p = 0; rv = 0; fl = 0;
        dec_a = '0; wb_a = '0; cmp_a = '0; cmp_d = '0; rdat = '0;
    endtask

    task automatic do_flush();
        fl = 1; cycle(); fl = 0;
    endtask

    task automatic drain(input int n);
        dec_p = 0; wb_p = 0; cmp_p = 0; fl = 0;
        repeat (n) begin
            rv = out_q.size() > 0;
            rdat = $urandom;
            cycle();
        end
        rv = 0;
    endtask

    initial begin
        idle_inputs();
        drive();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single dec read, response 3 cycles after the strobe
        dec_p = 1; dec_a = 'h10;
        cycle();
        cycle(); cycle(); cycle();
        rv = 1; rdat = 'hA5A5A5A5;
        cycle();
        rv = 0;
        cycle(); cycle();

        // all three clients requesting continuously
        do_flush();
        dec_a = 'h100; wb_a = 'h200; cmp_a = 'h300;
        for (int i = 0; i < 9; i++) begin
            dec_p = 1; wb_p = 1; cmp_p = 1;
            cmp_d = $urandom;
            rv = out_q.size() > 0;
            rdat = $urandom;
            cycle();
        end
        drain(6);

        // wb back-to-back reads until the tag FIFO fills
        do_flush();
        wb_ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            wb_p = 1; wb_a = AW'(32'h400 + 4 * i);
            cycle();
        end
        check("wb_acks_before_stall", wb_ack_cnt, 4);
        wb_p = 1; cmp_p = 1; cmp_a = 'h500; cmp_d = 'hDEADBEEF;
        cycle();
        wb_ack_cnt = 0;
        wb_p = 1; rv = 1; rdat = 'h11111111;
        cycle();
        rv = 0;
        wb_p = 1; cycle();
        wb_p = 1; cycle();
        check("wb_acks_after_one_rsp", wb_ack_cnt, 1);
        drain(8);

        // interleaved dec/wb reads, in-order responses
        do_flush();
        dec_p = 1; dec_a = 'h40; cycle();
        wb_p = 1; wb_a = 'h44; cycle();
        dec_p = 1; dec_a = 'h48; cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            rv = 1; rdat = D'(32'hC0DE0000 + i); cycle();
        end
        rv = 0;
        cycle(); cycle();

        // orphan response, then flush clears the error
        do_flush();
        rv = 1; rdat = 'h5A5A5A5A; cycle();
        rv = 0; cycle(); cycle();
        do_flush();
        cycle(); cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!dec_p && $urandom_range(2) == 0) begin dec_p = 1; dec_a = AW'($urandom_range(16'hFFFF)); end
            if (!wb_p && $urandom_range(2) == 0) begin wb_p = 1; wb_a = AW'($urandom_range(16'hFFFF)); end
            if (!cmp_p && $urandom_range(3) == 0) begin
                cmp_p = 1; cmp_a = AW'($urandom_range(16'hFFFF)); cmp_d = $urandom;
            end
            rv = (out_q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(39) == 0);
            rdat = $urandom;
            fl = ($urandom_range(49) == 0);
            cycle();
        end
        drain(8);

        // reset with three reads outstanding
        do_flush();
        dec_p = 1; dec_a = 'h60; cycle();
        wb_p = 1; wb_a = 'h64; cycle();
        dec_p = 1; dec_a = 'h68; cycle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        drive();
        #1;
        check_reset_outputs("midop_reset");
        cmd_q.delete(); rsp_q.delete(); out_q.delete();
        rr = 0; exp_err = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv = 1; rdat = $urandom; cycle();
        end
        rv = 0;
        cycle(); cycle();

        @(negedge clk);
        #1;
        check("cmd_queue_empty", cmd_q.size(), 0);
        check("rsp_queue_empty", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
